gpioemu_mulpop: RTL

GPIOEMU_MULPOP -- requirements
Module: gpioemu_mulpop

---
 rtl/gpioemu_mulpop.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop: bus-mapped shift-add multiplier with popcount of the product.
// Operands A1/A2 are written over a simple strobe bus; a control write starts an
// operation that runs IDLE -> MULT (DATA_W cycles) -> COUNT -> DONE and loads the
// W/WH/L result registers. A GPIO side port shows the operation counter and a
// latched copy of gpio_in.
module gpioemu_mulpop #(
  parameter int          DATA_W  = 24,
  parameter logic [15:0] ADDR_A1 = 16'h037F,
  parameter logic [15:0] ADDR_A2 = 16'h0388,
  parameter logic [15:0] ADDR_W  = 16'h0390,
  parameter logic [15:0] ADDR_WH = 16'h0394,
  parameter logic [15:0] ADDR_L  = 16'h0398,
  parameter logic [15:0] ADDR_B  = 16'h03A0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp,
  output logic        irq
);

  localparam int          PW       = 2 * DATA_W;
  localparam logic [5:0]  CNT_LAST = 6'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of set bits in a 64-bit word (product is zero-extended to 64 bits).
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  // Architectural registers
  state_t            state_q,     state_d;
  logic [DATA_W-1:0] a1_q,        a1_d;
  logic [DATA_W-1:0] a2_q,        a2_d;
  logic [31:0]       w_q,         w_d;
  logic [31:0]       wh_q,        wh_d;
  logic [31:0]       l_q,         l_d;
  logic [15:0]       op_count_q,  op_count_d;
  logic [31:0]       gpio_in_s_q, gpio_in_s_d;
  logic [31:0]       sdata_out_q, sdata_out_d;
  logic              done_q,      done_d;
  logic              ien_q,       ien_d;
  logic              ready_q,     ready_d;
  logic              valid_q,     valid_d;

  // Working registers of the running operation
  logic [PW-1:0]     mcand_q,     mcand_d;
  logic [DATA_W-1:0] mplier_q,    mplier_d;
  logic [PW-1:0]     acc_q,       acc_d;
  logic [5:0]        cnt_q,       cnt_d;
  logic [6:0]        pop_q,       pop_d;

  logic        wr_a1_s, wr_a2_s, wr_b_s, start_s;
  logic [63:0] prod_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign wr_a1_s  = swr && (saddress == ADDR_A1);
  assign wr_a2_s  = swr && (saddress == ADDR_A2);
  assign wr_b_s   = swr && (saddress == ADDR_B);
  // A start is only honoured from an idle, ready engine; anything else is dropped.
  assign start_s  = wr_b_s && sdata_in[0] && ready_q && (state_q == S_IDLE);
  assign prod_s   = 64'(acc_q);
  // Operand bits above DATA_W and unused control bits are intentionally ignored.
  assign unused_s = ^sdata_in;

  assign gpio_out       = {16'h0000, op_count_q};
  assign gpio_in_s_insp = gpio_in_s_q;
  assign sdata_out      = sdata_out_q;
  assign irq            = done_q & ien_q;

  // Read mux: values are the pre-edge register contents, unmapped addresses read 0.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (saddress)
      ADDR_A1: rdata_s = 32'(a1_q);
      ADDR_A2: rdata_s = 32'(a2_q);
      ADDR_W:  rdata_s = w_q;
      ADDR_WH: rdata_s = wh_q;
      ADDR_L:  rdata_s = l_q;
      ADDR_B:  rdata_s = {28'h0000000, ien_q, done_q, ready_q, valid_q};
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic: bus writes, read capture, GPIO latch and the operation FSM.
  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    w_d         = w_q;
    wh_d        = wh_q;
    l_d         = l_q;
    op_count_d  = op_count_q;
    gpio_in_s_d = gpio_in_s_q;
    sdata_out_d = sdata_out_q;
    done_d      = done_q;
    ien_d       = ien_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pop_d       = pop_q;

    // Operand writes land in the bus-visible registers only, never in the working copies.
    if (wr_a1_s) begin
      a1_d = sdata_in[DATA_W-1:0];
    end else begin
      a1_d = a1_q;
    end
    if (wr_a2_s) begin
      a2_d = sdata_in[DATA_W-1:0];
    end else begin
      a2_d = a2_q;
    end

    if (wr_b_s) begin
      ien_d = sdata_in[3];
      if (sdata_in[2]) begin
        done_d = 1'b0;
      end else begin
        done_d = done_q;
      end
    end else begin
      ien_d = ien_q;
    end

    if (srd) begin
      sdata_out_d = rdata_s;
    end else begin
      sdata_out_d = sdata_out_q;
    end

    if (gpio_latch) begin
      gpio_in_s_d = gpio_in;
    end else begin
      gpio_in_s_d = gpio_in_s_q;
    end

    // FSM assignments come last so they take priority over a done W1C on the same edge.
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          mcand_d  = PW'(a1_q);
          mplier_d = a2_q;
          acc_d    = '0;
          cnt_d    = 6'd0;
          ready_d  = 1'b0;
          done_d   = 1'b0;
          state_d  = S_MULT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_COUNT;
        end else begin
          state_d = S_MULT;
        end
      end
      S_COUNT: begin
        pop_d   = popcount64(prod_s);
        state_d = S_DONE;
      end
      S_DONE: begin
        w_d        = prod_s[31:0];
        wh_d       = prod_s[63:32];
        l_d        = {25'd0, pop_q};
        valid_d    = (prod_s[63:32] == 32'h0000_0000);
        done_d     = 1'b1;
        ready_d    = 1'b1;
        op_count_d = op_count_q + 16'd1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any running operation and restores idle status.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      a1_q        <= '0;
      a2_q        <= '0;
      w_q         <= 32'h0000_0000;
      wh_q        <= 32'h0000_0000;
      l_q         <= 32'h0000_0000;
      op_count_q  <= 16'h0000;
      gpio_in_s_q <= 32'h0000_0000;
      sdata_out_q <= 32'h0000_0000;
      done_q      <= 1'b0;
      ien_q       <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b1;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= 6'd0;
      pop_q       <= 7'd0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      w_q         <= w_d;
      wh_q        <= wh_d;
      l_q         <= l_d;
      op_count_q  <= op_count_d;
      gpio_in_s_q <= gpio_in_s_d;
      sdata_out_q <= sdata_out_d;
      done_q      <= done_d;
      ien_q       <= ien_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pop_q       <= pop_d;
    end
  end

endmodule
